mdu_iter: RTL

- Parametrised, self-contained RISC-V M-extension unit; next generation of the CPU-side multiply/divide block.
- Handles all eight funct3 ops for any XLEN on one shared iterative datapath.
  - Multiply: shift-add, MUL_BITS per cycle.
  - Divide: restoring, 1 bit per cycle.
- Valid/ready handshake on both sides, tag passthrough, flush input.
- Sits between the issue stage and writeback.

---
 rtl/mdu_iter.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RISC-V M-extension unit (shift-add multiply, restoring divide).
// Define MDU_OPCACHE_EN to add a single-entry divide result cache.
module mdu_iter #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 2,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int MUL_N = XLEN / MUL_BITS;
  localparam int CNT_W = $clog2(XLEN);
  localparam int PW    = 2 * XLEN;
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    cond_neg = neg ? -v : v;
  endfunction

  function automatic logic [PW-1:0] partial(input logic [PW-1:0] mc, input logic [MUL_BITS-1:0] bits);
    partial = {PW{1'b0}};
    for (int i = 0; i < MUL_BITS; i++) begin
      partial = partial + (bits[i] ? (mc << i) : {PW{1'b0}});
    end
  endfunction

  state_t             state_r;
  logic [2:0]         funct3_r;
  logic [TAG_W-1:0]   tag_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               is_mul_r;
  logic               neg_r;
  logic               rem_neg_r;
  logic [PW-1:0]      acc_r;
  logic [PW-1:0]      mcand_r;
  logic [XLEN-1:0]    mplier_r;
  logic               out_valid_r;
  logic [XLEN-1:0]    out_data_r;
  logic [TAG_W-1:0]   out_tag_r;

  logic               a_signed_s, b_signed_s, a_neg_s, b_neg_s;
  logic [XLEN-1:0]    mag_a_s, mag_b_s;
  logic               special_s;
  logic [XLEN-1:0]    special_data_s;
  logic               hit_s;
  logic [XLEN-1:0]    hit_data_s;
  logic               cur_mul_s;
  logic [PW-1:0]      cur_acc_s, cur_mcand_s, next_mcand_s;
  logic [XLEN-1:0]    cur_mplier_s;
  logic [XLEN:0]      rem_sh_s, diff_s;
  logic [PW-1:0]      step_acc_s, prod_s;
  logic [XLEN-1:0]    quo_s, rem_s, result_s;

  assign in_ready  = (state_r == IDLE);
  assign busy      = (state_r != IDLE);
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_tag   = out_tag_r;

  // Operand signedness, magnitudes and divide special cases for the incoming request.
  always_comb begin
    case (in_funct3)
      3'b001:         begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
      3'b010:         begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
      3'b100, 3'b110: begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
      default:        begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
    endcase
    a_neg_s = a_signed_s & in_a[XLEN-1];
    b_neg_s = b_signed_s & in_b[XLEN-1];
    mag_a_s = cond_neg(in_a, a_neg_s);
    mag_b_s = cond_neg(in_b, b_neg_s);
    special_data_s = {XLEN{1'b0}};
    if (in_funct3[2] && (in_b == {XLEN{1'b0}})) begin
      special_s      = 1'b1;
      special_data_s = in_funct3[1] ? in_a : ALL_ONES;
    end else if (in_funct3[2] && a_signed_s && (in_a == MOST_NEG) && (in_b == ALL_ONES)) begin
      special_s      = 1'b1;
      special_data_s = in_funct3[1] ? {XLEN{1'b0}} : MOST_NEG;
    end else begin
      special_s = 1'b0;
    end
  end

  // The accept edge performs the first step on fresh operands; later steps use the registers.
  always_comb begin
    if (state_r == IDLE) begin
      cur_mul_s    = ~in_funct3[2];
      cur_acc_s    = in_funct3[2] ? {{XLEN{1'b0}}, mag_a_s} : {PW{1'b0}};
      cur_mcand_s  = {{XLEN{1'b0}}, (in_funct3[2] ? mag_b_s : mag_a_s)};
      cur_mplier_s = mag_b_s;
    end else begin
      cur_mul_s    = is_mul_r;
      cur_acc_s    = acc_r;
      cur_mcand_s  = mcand_r;
      cur_mplier_s = mplier_r;
    end
    next_mcand_s = cur_mul_s ? (cur_mcand_s << MUL_BITS) : cur_mcand_s;
  end

  // One datapath step: shift-add for multiply, restoring subtract for divide ({rem, quo} in acc).
  always_comb begin
    rem_sh_s = cur_acc_s[PW-1:XLEN-1];
    diff_s   = rem_sh_s - {1'b0, cur_mcand_s[XLEN-1:0]};
    if (cur_mul_s) begin
      step_acc_s = cur_acc_s + partial(cur_mcand_s, cur_mplier_s[MUL_BITS-1:0]);
    end else if (!diff_s[XLEN]) begin
      step_acc_s = {diff_s[XLEN-1:0], cur_acc_s[XLEN-2:0], 1'b1};
    end else begin
      step_acc_s = {rem_sh_s[XLEN-1:0], cur_acc_s[XLEN-2:0], 1'b0};
    end
  end

  // Sign fix-up and result selection for the final step.
  always_comb begin
    prod_s = neg_r ? -step_acc_s : step_acc_s;
    quo_s  = cond_neg(step_acc_s[XLEN-1:0], neg_r);
    rem_s  = cond_neg(step_acc_s[PW-1:XLEN], rem_neg_r);
    case (funct3_r)
      3'b000:                 result_s = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result_s = prod_s[PW-1:XLEN];
      3'b100, 3'b101:         result_s = quo_s;
      default:                result_s = rem_s;
    endcase
  end

`ifdef MDU_OPCACHE_EN
  logic            cache_valid_r, cache_signed_r;
  logic [XLEN-1:0] opa_r, opb_r, cache_a_r, cache_b_r, cache_quo_r, cache_rem_r;
  logic            accept_s, fill_s;

  assign accept_s = (state_r == IDLE) && in_valid && !flush;
  assign fill_s   = (state_r == CALC) && !is_mul_r && (cnt_r == CNT_W'(1)) && !flush;

  // Divide cache: operands captured at accept, entry filled when an iterative divide completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_valid_r  <= 1'b0;
      cache_signed_r <= 1'b0;
      opa_r          <= {XLEN{1'b0}};
      opb_r          <= {XLEN{1'b0}};
      cache_a_r      <= {XLEN{1'b0}};
      cache_b_r      <= {XLEN{1'b0}};
      cache_quo_r    <= {XLEN{1'b0}};
      cache_rem_r    <= {XLEN{1'b0}};
    end else if (flush) begin
      cache_valid_r <= 1'b0;
    end else begin
      if (accept_s) begin
        opa_r <= in_a;
        opb_r <= in_b;
      end
      if (fill_s) begin
        cache_valid_r  <= 1'b1;
        cache_signed_r <= ~funct3_r[0];
        cache_a_r      <= opa_r;
        cache_b_r      <= opb_r;
        cache_quo_r    <= quo_s;
        cache_rem_r    <= rem_s;
      end
    end
  end

  assign hit_s      = cache_valid_r && (cache_a_r == in_a) && (cache_b_r == in_b) &&
                      (cache_signed_r == ~in_funct3[0]);
  assign hit_data_s = in_funct3[1] ? cache_rem_r : cache_quo_r;
`else
  assign hit_s      = 1'b0;
  assign hit_data_s = {XLEN{1'b0}};
`endif

  // Control FSM, iterative datapath registers and registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      funct3_r    <= 3'b000;
      tag_r       <= {TAG_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      is_mul_r    <= 1'b0;
      neg_r       <= 1'b0;
      rem_neg_r   <= 1'b0;
      acc_r       <= {PW{1'b0}};
      mcand_r     <= {PW{1'b0}};
      mplier_r    <= {XLEN{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {XLEN{1'b0}};
      out_tag_r   <= {TAG_W{1'b0}};
    end else if (flush) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            funct3_r  <= in_funct3;
            tag_r     <= in_tag;
            is_mul_r  <= cur_mul_s;
            neg_r     <= a_neg_s ^ b_neg_s;
            rem_neg_r <= a_neg_s;
            acc_r     <= step_acc_s;
            mcand_r   <= next_mcand_s;
            mplier_r  <= cur_mplier_s >> MUL_BITS;
            if (cur_mul_s) begin
              cnt_r   <= CNT_W'(MUL_N - 1);
              state_r <= CALC;
            end else if (special_s || hit_s) begin
              out_valid_r <= 1'b1;
              out_data_r  <= special_s ? special_data_s : hit_data_s;
              out_tag_r   <= in_tag;
              state_r     <= DONE;
            end else begin
              cnt_r   <= CNT_W'(XLEN - 1);
              state_r <= CALC;
            end
          end
        end
        CALC: begin
          acc_r    <= step_acc_s;
          mcand_r  <= next_mcand_s;
          mplier_r <= cur_mplier_s >> MUL_BITS;
          cnt_r    <= cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            out_valid_r <= 1'b1;
            out_data_r  <= result_s;
            out_tag_r   <= tag_r;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule
